// File: rtl/seg7_scan.sv
// Four-digit common-anode 7-segment scanner: frame-stable digit snapshot, per-slot ghosting guard.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan #(
    parameter int SCAN_DIV = 25000,
    parameter int GUARD    = 250
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DIN,
    input  logic [3:0]  DP,
    input  logic [3:0]  BLANK,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DPO,
    output logic        FRAME
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   sdin_q, sdin_d;
    logic [3:0]    sdp_q, sdp_d;
    logic [3:0]    sblank_q, sblank_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dpo_q, dpo_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          in_guard;
    logic [3:0]    lz_blank;
    logic [3:0]    cur_code;
    logic          dark;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // With no guard the comparison would be against zero; tie it off instead.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            localparam logic [PW-1:0] GLIM = PW'(GUARD);
            assign in_guard = (pcnt_q < GLIM);
        end
    endgenerate

`ifdef SEG7_LZB_EN
    assign lz_blank[3] = (sdin_q[15:12] == 4'h0);
    assign lz_blank[2] = lz_blank[3] && (sdin_q[11:8] == 4'h0);
    assign lz_blank[1] = lz_blank[2] && (sdin_q[7:4] == 4'h0);
    assign lz_blank[0] = 1'b0;
`else
    assign lz_blank = 4'b0000;
`endif

    assign tick     = (pcnt_q == PMAX);
    assign cur_code = sdin_q[{dig_q, 2'b00} +: 4];
    assign dark     = in_guard || sblank_q[dig_q] || lz_blank[dig_q];

    always_comb begin
        pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
        dig_d    = tick ? dig_q + 2'd1 : dig_q;
        sdin_d   = sdin_q;
        sdp_d    = sdp_q;
        sblank_d = sblank_q;
        frame_d  = 1'b0;
        // Snapshot on the same edge the digit index wraps back to 0.
        if (tick && (dig_q == 2'd3)) begin
            sdin_d   = DIN;
            sdp_d    = DP;
            sblank_d = BLANK;
            frame_d  = 1'b1;
        end
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dpo_d = 1'b1;
        if (!dark) begin
            an_d  = ~(4'b0001 << dig_q);
            seg_d = decode(cur_code);
            dpo_d = ~sdp_q[dig_q];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt_q   <= '0;
            dig_q    <= 2'd0;
            sdin_q   <= 16'h0000;
            sdp_q    <= 4'b0000;
            sblank_q <= 4'b1111;
            an_q     <= 4'b1111;
            seg_q    <= 7'h7F;
            dpo_q    <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            dig_q    <= dig_d;
            sdin_q   <= sdin_d;
            sdp_q    <= sdp_d;
            sblank_q <= sblank_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dpo_q    <= dpo_d;
            frame_q  <= frame_d;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DPO   = dpo_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: SCAN_DIV=8/GUARD=2 main instance plus a SCAN_DIV=2/GUARD=0 instance.
module tb_seg7_scan;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] DIN = 16'h1234;
    logic [3:0]  DP = 4'b0000;
    logic [3:0]  BLANK = 4'b0000;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DPO;
    logic        FRAME;

    logic [15:0] din2 = 16'h1234;
    logic [3:0]  dp2 = 4'b0000;
    logic [3:0]  blank2 = 4'b0000;
    logic [3:0]  an2;
    logic [6:0]  seg2;
    logic        dpo2;
    logic        frame2;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;

    always #5 CLK = ~CLK;

    seg7_scan #(.SCAN_DIV(8), .GUARD(2)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DP(DP), .BLANK(BLANK),
        .AN(AN), .SEG(SEG), .DPO(DPO), .FRAME(FRAME)
    );

    seg7_scan #(.SCAN_DIV(2), .GUARD(0)) dut2 (
        .CLK(CLK), .RST(RST), .DIN(din2), .DP(dp2), .BLANK(blank2),
        .AN(an2), .SEG(seg2), .DPO(dpo2), .FRAME(frame2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got=%h expected=%h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        k++;
    endtask

    // Packs {FRAME, AN, SEG, DPO} of the main instance.
    function automatic logic [31:0] obs1();
        return {19'd0, FRAME, AN, SEG, DPO};
    endfunction

    localparam logic [31:0] RESET_VEC = {19'd0, 1'b0, 4'b1111, 7'h7F, 1'b1};

    // One 32-cycle frame of the main instance; segs = {d3,d2,d1,d0}, dpo = per-digit DPO when lit.
    task automatic check_frame(input string tag, input logic [3:0] lit, input logic [27:0] segs,
                               input logic [3:0] dpo, input int chg_at, input logic [15:0] cdin,
                               input logic [3:0] cdp, input logic [3:0] cblank);
        int m, p, d;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dpo, e_frm;
        for (int i = 0; i < 32; i++) begin
            if (i == chg_at) begin
                DIN = cdin;
                DP = cdp;
                BLANK = cblank;
            end
            step();
            m = k - 1;
            p = m % 8;
            d = (m / 8) % 4;
            e_frm = ((k % 32) == 0);
            e_an = 4'b1111;
            e_seg = 7'h7F;
            e_dpo = 1'b1;
            if (p >= 2 && lit[d]) begin
                e_an = ~(4'b0001 << d);
                e_seg = segs[d*7 +: 7];
                e_dpo = dpo[d];
            end
            check_eq(tag, obs1(), {19'd0, e_frm, e_an, e_seg, e_dpo});
        end
    endtask

    initial begin
        // Reset with live inputs: outputs at reset values.
        step();
        check_eq("reset0", obs1(), RESET_VEC);
        step();
        check_eq("reset1", obs1(), RESET_VEC);
        RST = 1'b0;
        DIN = 16'h0759;
        DP = 4'b0100;
        k = 0;

        check_frame("first_dark", 4'b0000, 28'h0, 4'hF, -1, 16'h0, 4'h0, 4'h0);
        check_frame("scan_f1", 4'b1111, {7'h40, 7'h78, 7'h12, 7'h10}, 4'b1011, -1, 16'h0, 4'h0, 4'h0);
        DIN = 16'h0000;
        DP = 4'b0000;
        check_frame("scan_f2", 4'b1111, {7'h40, 7'h78, 7'h12, 7'h10}, 4'b1011, -1, 16'h0, 4'h0, 4'h0);

        // Mid-frame change must not appear until the next frame.
        check_frame("tear_cur", 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 13, 16'hFFFF, 4'h0, 4'h0);
        check_frame("tear_next", 4'b1111, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b1111, 13, 16'hFFFF, 4'hF, 4'b1010);
        check_frame("blank", 4'b0101, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b0000, -1, 16'h0, 4'h0, 4'h0);

        // Mid-slot reset, then no partial snapshot survives.
        repeat (4) step();
        check_eq("pre_rst_lit", obs1(), {19'd0, 1'b0, 4'b1110, 7'h0E, 1'b0});
        RST = 1'b1;
        step();
        check_eq("mid_rst", obs1(), RESET_VEC);
        RST = 1'b0;
        DIN = 16'h1234;
        BLANK = 4'b0000;
        k = 0;
        check_frame("post_rst_dark", 4'b0000, 28'h0, 4'hF, -1, 16'h0, 4'h0, 4'h0);
        check_frame("post_rst_f1", 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, -1, 16'h0, 4'h0, 4'h0);

        // GUARD=0, SCAN_DIV=2 instance: 8-cycle frames, always exactly one anode low once valid.
        RST = 1'b1;
        step();
        check_eq("g0_reset", {19'd0, frame2, an2, seg2, dpo2}, RESET_VEC);
        RST = 1'b0;
        k = 0;
        for (int i = 0; i < 24; i++) begin
            int d2;
            logic [6:0] e_seg2;
            logic [3:0] e_an2;
            step();
            d2 = ((k - 1) / 2) % 4;
            case (d2)
                0: e_seg2 = 7'h19;
                1: e_seg2 = 7'h30;
                2: e_seg2 = 7'h24;
                default: e_seg2 = 7'h79;
            endcase
            e_an2 = ~(4'b0001 << d2);
            if (k < 9) begin
                e_an2 = 4'b1111;
                e_seg2 = 7'h7F;
            end
            check_eq("guard0", {19'd0, frame2, an2, seg2, dpo2},
                     {19'd0, (k % 8) == 0, e_an2, e_seg2, 1'b1});
        end

`ifdef SEG7_LZB_EN
        RST = 1'b1;
        DIN = 16'h0005;
        DP = 4'b0000;
        BLANK = 4'b0000;
        step();
        RST = 1'b0;
        k = 0;
        check_frame("lzb_dark", 4'b0000, 28'h0, 4'hF, -1, 16'h0, 4'h0, 4'h0);
        check_frame("lzb_0005", 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111, 0, 16'h0105, 4'h0, 4'h0);
        check_frame("lzb_0105", 4'b0111, {7'h7F, 7'h79, 7'h40, 7'h12}, 4'b1111, 0, 16'h0000, 4'h0, 4'h0);
        check_frame("lzb_0000", 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, -1, 16'h0, 4'h0, 4'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
